// File: rtl/pixel_stream_pkg.sv
// Shared types for the pixel stream sequencer: FSM states, per-request tag
// and the FIFO pointer width helper.
package pixel_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   typedef struct packed {
      logic sof;
      logic eol;
   } tag_t;

   // One extra bit so a full FIFO is distinguishable from an empty one.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pixel_stream_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
// Push and pop may happen in the same cycle; the caller never overfills it.
module pixel_stream_fifo
   import pixel_stream_pkg::*;
#(
   parameter int WIDTH = 26,
   parameter int DEPTH = 8,
   localparam int PTR_W = ptr_w(DEPTH)
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic [PTR_W-1:0] count,
   output logic             empty
);

   localparam int AW = PTR_W - 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pixel_stream_sequencer.sv
// Raster-scans a WIDTH x HEIGHT frame, reads pixels from a fixed-latency
// source and emits them as AXI4-Stream video (tuser = SOF, tlast = EOL).
module pixel_stream_sequencer
   import pixel_stream_pkg::*;
#(
   parameter int DATA_W     = 24,
   parameter int X_W        = 11,
   parameter int Y_W        = 11,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              cfg_enable,
   input  logic [X_W-1:0]    cfg_width,
   input  logic [Y_W-1:0]    cfg_height,
   output logic              pix_rd_en,
   output logic [X_W-1:0]    pix_rd_x,
   output logic [Y_W-1:0]    pix_rd_y,
   input  logic [DATA_W-1:0] pix_rd_data,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tuser,
   output logic              m_axis_tlast,
   output logic              busy,
   output logic              frame_done,
   output logic              cfg_err
);

   localparam int PTR_W = ptr_w(FIFO_DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      tag_t              tag;
   } entry_t;

   state_e            state_q, state_d;
   logic [X_W-1:0]    w_q, x_q;
   logic [Y_W-1:0]    h_q, y_q;
   logic [RD_LAT:1]   vld_pipe;
   tag_t              tag_pipe [1:RD_LAT];
   tag_t              tag_in;
   logic [PTR_W-1:0]  fifo_count, inflight;
   logic              fifo_empty, credit_ok, drained, cfg_ok, last_x, last_px;
   logic              issue, latch, err_set, pop;
   entry_t            wr_entry, head;

   assign cfg_ok  = (cfg_width != '0) && (cfg_height != '0);
   assign last_x  = (x_q == w_q - 1'b1);
   assign last_px = last_x && (y_q == h_q - 1'b1);
   assign tag_in  = '{sof: (x_q == '0) && (y_q == '0), eol: last_x};

   always_comb begin
      inflight = '0;
      for (int i = 1; i <= RD_LAT; i++) inflight = inflight + PTR_W'(vld_pipe[i]);
   end

   // Requests in flight already own a FIFO slot, so the FIFO can never overflow.
   assign credit_ok = (fifo_count + inflight) < PTR_W'(FIFO_DEPTH);
   assign drained   = (inflight == '0) && fifo_empty;

   always_ff @(posedge ACLK) begin
      if (!ARESETN) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (cfg_enable && cfg_ok) state_d = ST_ACTIVE;
         ST_ACTIVE: if (issue && last_px)     state_d = ST_DRAIN;
         ST_DRAIN:  if (drained) state_d = (cfg_enable && cfg_ok) ? ST_ACTIVE : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      issue      = 1'b0;
      latch      = 1'b0;
      err_set    = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            latch   = cfg_enable && cfg_ok;
            err_set = cfg_enable && !cfg_ok;
         end
         ST_ACTIVE: begin
            busy  = 1'b1;
            issue = credit_ok;
         end
         ST_DRAIN: begin
            busy       = 1'b1;
            frame_done = drained;
            latch      = drained && cfg_enable && cfg_ok;
         end
         default: ;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         w_q      <= '0;
         h_q      <= '0;
         x_q      <= '0;
         y_q      <= '0;
         vld_pipe <= '0;
         cfg_err  <= 1'b0;
         for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= '0;
      end else begin
         if (err_set) cfg_err <= 1'b1;
         if (latch) begin
            w_q <= cfg_width;
            h_q <= cfg_height;
            x_q <= '0;
            y_q <= '0;
         end else if (issue) begin
            if (last_x) begin
               x_q <= '0;
               y_q <= y_q + 1'b1;
            end else begin
               x_q <= x_q + 1'b1;
            end
         end
         vld_pipe[1] <= issue;
         tag_pipe[1] <= tag_in;
         for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   assign pix_rd_en = issue;
   assign pix_rd_x  = issue ? x_q : '0;
   assign pix_rd_y  = issue ? y_q : '0;

   assign wr_entry = '{data: pix_rd_data, tag: tag_pipe[RD_LAT]};

   pixel_stream_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .push    (vld_pipe[RD_LAT]),
      .wr_data (wr_entry),
      .pop     (pop),
      .rd_data (head),
      .count   (fifo_count),
      .empty   (fifo_empty)
   );

   // Head is gated so stale FIFO storage never shows on the bus.
   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = m_axis_tvalid ? head.data : '0;
   assign m_axis_tuser  = m_axis_tvalid && head.tag.sof;
   assign m_axis_tlast  = m_axis_tvalid && head.tag.eol;
   assign pop           = m_axis_tvalid && m_axis_tready;

endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// Directed bench for pixel_stream_sequencer: fixed-latency pixel source model,
// stream monitor and hand-computed expectations per frame.
module tb_pixel_stream_sequencer;

   localparam int DATA_W = 24;
   localparam int X_W    = 11;
   localparam int Y_W    = 11;
   localparam int RD_LAT = 2;

   logic              ACLK = 1'b0;
   logic              ARESETN;
   logic              cfg_enable;
   logic [X_W-1:0]    cfg_width;
   logic [Y_W-1:0]    cfg_height;
   logic              pix_rd_en;
   logic [X_W-1:0]    pix_rd_x;
   logic [Y_W-1:0]    pix_rd_y;
   logic [DATA_W-1:0] pix_rd_data;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tuser;
   logic              m_axis_tlast;
   logic              busy;
   logic              frame_done;
   logic              cfg_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 ACLK = ~ACLK;

   pixel_stream_sequencer dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .cfg_enable    (cfg_enable),
      .cfg_width     (cfg_width),
      .cfg_height    (cfg_height),
      .pix_rd_en     (pix_rd_en),
      .pix_rd_x      (pix_rd_x),
      .pix_rd_y      (pix_rd_y),
      .pix_rd_data   (pix_rd_data),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy),
      .frame_done    (frame_done),
      .cfg_err       (cfg_err)
   );

   // Pixel source: returns {y,x} RD_LAT cycles after the request is sampled.
   logic [DATA_W-1:0] src_pipe [1:RD_LAT];
   always @(posedge ACLK) begin
      src_pipe[1] <= pix_rd_en ? {2'b00, pix_rd_y, pix_rd_x} : 24'hBAD000;
      for (int k = 2; k <= RD_LAT; k++) src_pipe[k] <= src_pipe[k-1];
   end
   assign pix_rd_data = src_pipe[RD_LAT];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] pix(input int x, input int y);
      logic [X_W-1:0] xx;
      logic [Y_W-1:0] yy;
      xx = X_W'(x);
      yy = Y_W'(y);
      return {2'b00, yy, xx};
   endfunction

   // Monitor: everything sampled on the falling edge.
   logic [DATA_W-1:0] q_data [$];
   logic              q_user [$];
   logic              q_last [$];
   int n_reads, n_done, max_out, cyc, first_busy, first_valid;
   logic stall_prev = 1'b0;
   logic [DATA_W-1:0] prev_data;
   logic prev_user, prev_last;

   always @(negedge ACLK) begin
      cyc++;
      if (pix_rd_en) n_reads++;
      if (frame_done) n_done++;
      if (n_reads - q_data.size() > max_out) max_out = n_reads - q_data.size();
      if (busy && first_busy < 0) first_busy = cyc;
      if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
      if (stall_prev) begin
         chk("stall_valid", m_axis_tvalid, 1);
         chk("stall_data", m_axis_tdata, prev_data);
         chk("stall_user", m_axis_tuser, prev_user);
         chk("stall_last", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
         q_data.push_back(m_axis_tdata);
         q_user.push_back(m_axis_tuser);
         q_last.push_back(m_axis_tlast);
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_user  = m_axis_tuser;
      prev_last  = m_axis_tlast;
   end

   task automatic clear_mon();
      q_data.delete();
      q_user.delete();
      q_last.delete();
      n_reads = 0;
      n_done = 0;
      max_out = 0;
      first_busy = -1;
      first_valid = -1;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_rd_en"}, pix_rd_en, 0);
      chk({tag, "_rd_x"}, pix_rd_x, 0);
      chk({tag, "_rd_y"}, pix_rd_y, 0);
      chk({tag, "_tvalid"}, m_axis_tvalid, 0);
      chk({tag, "_tdata"}, m_axis_tdata, 0);
      chk({tag, "_tuser"}, m_axis_tuser, 0);
      chk({tag, "_tlast"}, m_axis_tlast, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, frame_done, 0);
      chk({tag, "_err"}, cfg_err, 0);
   endtask

   task automatic wait_busy(input string tag, input int budget);
      logic ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge ACLK);
         if (busy) begin ok = 1'b1; break; end
      end
      chk({tag, "_busy_timeout"}, ok, 1);
   endtask

   // Returns on the falling edge where frame_done is seen; optionally toggles tready.
   task automatic wait_done(input string tag, input int budget, input bit toggle);
      logic ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge ACLK); #1;
         if (toggle) m_axis_tready = ~m_axis_tready;
         @(negedge ACLK);
         if (frame_done) begin ok = 1'b1; break; end
      end
      chk({tag, "_done_timeout"}, ok, 1);
   endtask

   task automatic check_frame(input string tag, input int w, input int h, input int base);
      for (int i = 0; i < w * h && base + i < q_data.size(); i++) begin
         chk($sformatf("%s_data%0d", tag, i), q_data[base+i], pix(i % w, i / w));
         chk($sformatf("%s_user%0d", tag, i), q_user[base+i], (i == 0));
         chk($sformatf("%s_last%0d", tag, i), q_last[base+i], (i % w == w - 1));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge ACLK);
      #1;
   endtask

   initial begin
      ARESETN = 1'b0;
      cfg_enable = 1'b0;
      cfg_width = '0;
      cfg_height = '0;
      m_axis_tready = 1'b1;
      clear_mon();
      idle(3);
      check_zero_outputs("reset");
      ARESETN = 1'b1;
      idle(2);

      // 4x2 frame, free-running sink
      clear_mon();
      cfg_width = 4; cfg_height = 2; cfg_enable = 1'b1;
      wait_busy("f1", 20);
      @(posedge ACLK); #1 cfg_enable = 1'b0;
      wait_done("f1", 100, 1'b0);
      chk("f1_busy_at_done", busy, 1);
      @(negedge ACLK);
      chk("f1_busy_after", busy, 0);
      idle(10);
      chk("f1_beats", q_data.size(), 8);
      check_frame("f1", 4, 2, 0);
      chk("f1_reads", n_reads, 8);
      chk("f1_done_pulses", n_done, 1);
      chk("f1_latency", first_valid - first_busy, RD_LAT + 1);

      // 4x4 frame with a stalled then toggling sink: credits cap outstanding reads
      clear_mon();
      m_axis_tready = 1'b0;
      cfg_width = 4; cfg_height = 4; cfg_enable = 1'b1;
      wait_busy("f2", 20);
      @(posedge ACLK); #1 cfg_enable = 1'b0;
      idle(30);
      chk("f2_stalled_reads", n_reads, 8);
      wait_done("f2", 300, 1'b1);
      m_axis_tready = 1'b1;
      idle(10);
      chk("f2_beats", q_data.size(), 16);
      check_frame("f2", 4, 4, 0);
      chk("f2_max_outstanding", max_out <= 8, 1);
      chk("f2_done_pulses", n_done, 1);
      chk("f2_busy", busy, 0);

      // zero width: no reads, sticky error
      clear_mon();
      cfg_width = 0; cfg_height = 2; cfg_enable = 1'b1;
      idle(10);
      chk("f3_reads", n_reads, 0);
      chk("f3_err", cfg_err, 1);
      chk("f3_busy", busy, 0);
      cfg_enable = 1'b0;
      idle(5);
      chk("f3_err_sticky", cfg_err, 1);
      chk("f3_tvalid", m_axis_tvalid, 0);

      // 3x3 frame, enable dropped after the second beat
      clear_mon();
      cfg_width = 3; cfg_height = 3; cfg_enable = 1'b1;
      begin
         logic ok = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (q_data.size() >= 2) begin ok = 1'b1; break; end
         end
         chk("f4_two_beats_timeout", ok, 1);
      end
      @(posedge ACLK); #1 cfg_enable = 1'b0;
      wait_done("f4", 100, 1'b0);
      idle(12);
      chk("f4_beats", q_data.size(), 9);
      check_frame("f4", 3, 3, 0);
      chk("f4_reads", n_reads, 9);
      chk("f4_busy", busy, 0);
      chk("f4_done_pulses", n_done, 1);

      // enable held: 2x2 then width changed to 3 mid-frame takes effect next frame
      clear_mon();
      cfg_width = 2; cfg_height = 2; cfg_enable = 1'b1;
      wait_busy("f5", 20);
      @(posedge ACLK); #1 cfg_width = 3;
      wait_done("f5a", 100, 1'b0);
      @(posedge ACLK); #1 cfg_enable = 1'b0;
      wait_done("f5b", 100, 1'b0);
      idle(10);
      chk("f5_beats", q_data.size(), 10);
      check_frame("f5a", 2, 2, 0);
      check_frame("f5b", 3, 2, 4);
      chk("f5_done_pulses", n_done, 2);
      chk("f5_busy", busy, 0);

      // reset mid-frame, then a 1x1 frame
      cfg_width = 4; cfg_height = 2; cfg_enable = 1'b1;
      idle(5);
      ARESETN = 1'b0;
      cfg_width = 1; cfg_height = 1;
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      check_zero_outputs("f6_reset");
      clear_mon();
      wait_busy("f6", 20);
      @(posedge ACLK); #1 cfg_enable = 1'b0;
      wait_done("f6", 50, 1'b0);
      idle(10);
      chk("f6_beats", q_data.size(), 1);
      if (q_data.size() >= 1) begin
         chk("f6_data", q_data[0], pix(0, 0));
         chk("f6_user", q_user[0], 1);
         chk("f6_last", q_last[0], 1);
      end
      chk("f6_reads", n_reads, 1);
      chk("f6_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
